// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, zero-seed lock-up guard and period measurement.
// Latency: zero pipeline; q reflects a load or step on the same rising edge.
// Backpressure: none; load/en are sampled every edge (load > en > hold), the source always accepts.
module lfsr_gen #(
    parameter int           N      = 8,
    parameter logic [N-1:0] TAPS   = 8'hB8,
    parameter logic [1:N]   SEED   = '1,
    parameter bit           GALOIS = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [1:N]   seed_in,
    output logic [1:N]   q,
    output logic         out_bit,
    output logic [N-1:0] step_cnt,
    output logic [N-1:0] period_len,
    output logic         period_done,
    output logic         lock_err
);

    // State the current period is measured against; rewritten on every load and reset.
    logic [1:N]   ref_q;
    // q with stage numbering mapped onto TAPS bit positions: q_rev[i-1] = q[i].
    logic [N-1:0] q_rev;
    logic         fb;
    logic [1:N]   fib_nxt;
    logic [1:N]   gal_nxt;
    logic [1:N]   nxt;

    for (genvar g = 1; g <= N; g++) begin : g_rev
        assign q_rev[g-1] = q[g];
    end

    assign out_bit = q[N];

    // Next-state for both structures; the parameter picks one and the other is trimmed away.
    always_comb begin
        fb      = ^(q_rev & TAPS);
        fib_nxt = {fb, q[1:N-1]};
        // Stage i (2..N) takes q[i-1] XOR (q[N] & TAPS[N-i]); TAPS[N-2:0] lines up MSB-first with stages 2..N.
        gal_nxt = {q[N], q[1:N-1] ^ ({(N-1){q[N]}} & TAPS[N-2:0])};
        nxt     = GALOIS ? gal_nxt : fib_nxt;
    end

    // Shift register, reference, step counter and the two single-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q           <= SEED;
            ref_q       <= SEED;
            step_cnt    <= '0;
            period_len  <= '0;
            period_done <= 1'b0;
            lock_err    <= 1'b0;
        end else begin
            period_done <= 1'b0;
            lock_err    <= 1'b0;
            if (load) begin
                step_cnt <= '0;
                if (seed_in == '0) begin
                    // All-zero is a lock-up state for an XOR LFSR; substitute the reset seed instead.
                    q        <= SEED;
                    ref_q    <= SEED;
                    lock_err <= 1'b1;
                end else begin
                    q     <= seed_in;
                    ref_q <= seed_in;
                end
            end else if (en) begin
                q <= nxt;
                if (nxt == ref_q) begin
                    step_cnt    <= '0;
                    period_len  <= step_cnt + 1'b1;
                    period_done <= 1'b1;
                end else if (step_cnt != '1) begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: N=3 Fibonacci and Galois vector tables, zero-seed, load priority,
// asynchronous mid-run reset, and an 8-bit free run against a reference model.
// Inputs driven #1 after the rising edge; outputs sampled #1 after the following rising edge.
module tb_lfsr_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // N=3 Fibonacci instance
    logic       f_en = 1'b0, f_load = 1'b0;
    logic [1:3] f_seed = '0;
    logic [1:3] f_q;
    logic       f_out, f_done, f_lock;
    logic [2:0] f_cnt, f_plen;

    // N=3 Galois instance
    logic       g_en = 1'b0, g_load = 1'b0;
    logic [1:3] g_seed = '0;
    logic [1:3] g_q;
    logic       g_out, g_done, g_lock;
    logic [2:0] g_cnt, g_plen;

    // N=8 default instance
    logic       w_en = 1'b0, w_load = 1'b0;
    logic [1:8] w_seed = '0;
    logic [1:8] w_q;
    logic       w_out, w_done, w_lock;
    logic [7:0] w_cnt, w_plen;

    lfsr_gen #(.N(3), .TAPS(3'b110), .SEED(3'b111), .GALOIS(1'b0)) u_f3 (
        .clk(clk), .rst(rst), .en(f_en), .load(f_load), .seed_in(f_seed),
        .q(f_q), .out_bit(f_out), .step_cnt(f_cnt), .period_len(f_plen),
        .period_done(f_done), .lock_err(f_lock));

    lfsr_gen #(.N(3), .TAPS(3'b110), .SEED(3'b111), .GALOIS(1'b1)) u_g3 (
        .clk(clk), .rst(rst), .en(g_en), .load(g_load), .seed_in(g_seed),
        .q(g_q), .out_bit(g_out), .step_cnt(g_cnt), .period_len(g_plen),
        .period_done(g_done), .lock_err(g_lock));

    lfsr_gen u_w8 (
        .clk(clk), .rst(rst), .en(w_en), .load(w_load), .seed_in(w_seed),
        .q(w_q), .out_bit(w_out), .step_cnt(w_cnt), .period_len(w_plen),
        .period_done(w_done), .lock_err(w_lock));

    typedef struct {
        logic       en;
        logic       load;
        logic [2:0] seed;
        logic [2:0] q;
        logic [2:0] cnt;
        logic [2:0] plen;
        logic       done;
        logic       lock;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    vec_t ftab[17];
    vec_t gtab[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic load, input logic [2:0] seed,
                                input logic [2:0] q, input logic [2:0] cnt, input logic [2:0] plen,
                                input logic done, input logic lock);
        vec_t v;
        v.en = en; v.load = load; v.seed = seed; v.q = q;
        v.cnt = cnt; v.plen = plen; v.done = done; v.lock = lock;
        return v;
    endfunction

    // Drive one vector into the chosen N=3 instance, push its expectation, compare after the edge.
    task automatic run_vec(input bit gal, input int idx, input vec_t v);
        vec_t       e;
        string      p;
        logic [2:0] aq, acnt, aplen;
        logic       aout, adone, alock;
        if (gal) begin
            g_en = v.en; g_load = v.load; g_seed = v.seed;
        end else begin
            f_en = v.en; f_load = v.load; f_seed = v.seed;
        end
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (gal) begin
            aq = g_q; acnt = g_cnt; aplen = g_plen; aout = g_out; adone = g_done; alock = g_lock;
        end else begin
            aq = f_q; acnt = f_cnt; aplen = f_plen; aout = f_out; adone = f_done; alock = f_lock;
        end
        p = $sformatf("%s%0d", gal ? "gal" : "fib", idx);
        chk({p, ".q"},    32'(aq),    32'(e.q));
        chk({p, ".out"},  32'(aout),  32'(e.q[0]));
        chk({p, ".cnt"},  32'(acnt),  32'(e.cnt));
        chk({p, ".plen"}, 32'(aplen), 32'(e.plen));
        chk({p, ".done"}, 32'(adone), 32'(e.done));
        chk({p, ".lock"}, 32'(alock), 32'(e.lock));
    endtask

    initial begin
        logic [1:8] m;
        logic       mfb;
        bit         seen[256];
        int         rep;

        // Fibonacci N=3: full period from reset seed, then zero-seed, load priority and hold.
        ftab[0]  = mk(1, 0, 3'b000, 3'b011, 1, 0, 0, 0);
        ftab[1]  = mk(1, 0, 3'b000, 3'b001, 2, 0, 0, 0);
        ftab[2]  = mk(1, 0, 3'b000, 3'b100, 3, 0, 0, 0);
        ftab[3]  = mk(1, 0, 3'b000, 3'b010, 4, 0, 0, 0);
        ftab[4]  = mk(1, 0, 3'b000, 3'b101, 5, 0, 0, 0);
        ftab[5]  = mk(1, 0, 3'b000, 3'b110, 6, 0, 0, 0);
        ftab[6]  = mk(1, 0, 3'b000, 3'b111, 0, 7, 1, 0);
        ftab[7]  = mk(1, 0, 3'b000, 3'b011, 1, 7, 0, 0);
        ftab[8]  = mk(0, 1, 3'b000, 3'b111, 0, 7, 0, 1);
        ftab[9]  = mk(0, 0, 3'b000, 3'b111, 0, 7, 0, 0);
        ftab[10] = mk(1, 1, 3'b010, 3'b010, 0, 7, 0, 0);
        for (int i = 11; i < 16; i++) ftab[i] = mk(0, 0, 3'b000, 3'b010, 0, 7, 0, 0);
        ftab[16] = mk(1, 0, 3'b000, 3'b101, 1, 7, 0, 0);

        // Galois N=3: load 100 then one full period.
        gtab[0] = mk(0, 1, 3'b100, 3'b100, 0, 0, 0, 0);
        gtab[1] = mk(1, 0, 3'b000, 3'b010, 1, 0, 0, 0);
        gtab[2] = mk(1, 0, 3'b000, 3'b001, 2, 0, 0, 0);
        gtab[3] = mk(1, 0, 3'b000, 3'b110, 3, 0, 0, 0);
        gtab[4] = mk(1, 0, 3'b000, 3'b011, 4, 0, 0, 0);
        gtab[5] = mk(1, 0, 3'b000, 3'b111, 5, 0, 0, 0);
        gtab[6] = mk(1, 0, 3'b000, 3'b101, 6, 0, 0, 0);
        gtab[7] = mk(1, 0, 3'b000, 3'b100, 0, 7, 1, 0);
        gtab[8] = mk(0, 0, 3'b000, 3'b100, 0, 7, 0, 0);

        // Reset state
        #12;
        chk("rst.f_q",    32'(f_q),    32'h7);
        chk("rst.f_cnt",  32'(f_cnt),  32'h0);
        chk("rst.f_plen", 32'(f_plen), 32'h0);
        chk("rst.f_done", 32'(f_done), 32'h0);
        chk("rst.f_lock", 32'(f_lock), 32'h0);
        chk("rst.g_q",    32'(g_q),    32'h7);
        chk("rst.w_q",    32'(w_q),    32'hFF);
        chk("rst.w_plen", 32'(w_plen), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(1'b0, i, ftab[i]);
        f_en = 1'b0; f_load = 1'b0;
        for (int i = 0; i < 9; i++) run_vec(1'b1, i, gtab[i]);
        g_en = 1'b0; g_load = 1'b0;

        // Asynchronous reset between edges after 4 steps
        f_en = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #1;
        rst = 1'b0;
        #1;
        chk("arst.f_q",    32'(f_q),    32'h7);
        chk("arst.f_cnt",  32'(f_cnt),  32'h0);
        chk("arst.f_plen", 32'(f_plen), 32'h0);
        chk("arst.g_plen", 32'(g_plen), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int s = 1; s <= 7; s++) begin
            @(posedge clk);
            #1;
            chk($sformatf("arst.done%0d", s), 32'(f_done), 32'(s == 7));
        end
        chk("arst.f_q_wrap", 32'(f_q),    32'h7);
        chk("arst.f_plen7",  32'(f_plen), 32'h7);
        f_en = 1'b0;

        // 8-bit free run against the x^8+x^6+x^5+x^4+1 reference model
        m   = 8'hFF;
        rep = 0;
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        seen[255] = 1'b1;
        w_en = 1'b1;
        for (int s = 1; s <= 255; s++) begin
            mfb = m[4] ^ m[5] ^ m[6] ^ m[8];
            m   = {mfb, m[1:7]};
            @(posedge clk);
            #1;
            chk($sformatf("w8.q%0d", s),    32'(w_q),    32'(m));
            chk($sformatf("w8.done%0d", s), 32'(w_done), 32'(s == 255));
            chk($sformatf("w8.cnt%0d", s),  32'(w_cnt),  (s == 255) ? 32'd0 : 32'(s));
            if (s < 255 && seen[m]) rep++;
            seen[m] = 1'b1;
        end
        w_en = 1'b0;
        chk("w8.norepeat", 32'(rep),    32'd0);
        chk("w8.plen",     32'(w_plen), 32'd255);
        @(posedge clk);
        #1;
        chk("w8.done_clear", 32'(w_done), 32'h0);
        chk("w8.hold_q",     32'(w_q),    32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
